// File: rtl/fetch_stage_if.sv
// ---------------------------------------------------------------------------
// fetch_stage_if
//
// Bundles every non-clock, non-reset signal of the RV32I fetch stage:
//   instruction-memory request/response channel
//     o_imem_req     fetch stage -> memory   request valid
//     o_imem_addr    fetch stage -> memory   word-aligned byte address
//     i_imem_rdy     memory -> fetch stage   request accepted this cycle
//     i_imem_rvalid  memory -> fetch stage   read data valid
//     i_imem_rdata   memory -> fetch stage   instruction word
//   pipeline control from decode/execute
//     i_stall        decode cannot accept, hold IF/ID
//     i_flush        kill IF/ID and the hold buffer
//     i_redirect     taken branch/jump, restart fetch
//     i_redirect_pc  redirect target (low two bits ignored)
//   IF/ID pipeline register towards decode
//     o_id_valid     slot holds a live instruction
//     o_id_inst      instruction (NOP when invalid)
//     o_id_pc        PC of o_id_inst
//     o_id_pc4       o_id_pc + 4
//
// The i_/o_ prefixes are from the fetch stage's point of view; the
// "master" modport is the fetch stage, "slave" is its environment
// (memory plus the rest of the pipeline).
// ---------------------------------------------------------------------------
interface fetch_stage_if;
    logic        o_imem_req;
    logic [31:0] o_imem_addr;
    logic        i_imem_rdy;
    logic        i_imem_rvalid;
    logic [31:0] i_imem_rdata;

    logic        i_stall;
    logic        i_flush;
    logic        i_redirect;
    logic [31:0] i_redirect_pc;

    logic        o_id_valid;
    logic [31:0] o_id_inst;
    logic [31:0] o_id_pc;
    logic [31:0] o_id_pc4;

    modport master (
        output o_imem_req,
        output o_imem_addr,
        input  i_imem_rdy,
        input  i_imem_rvalid,
        input  i_imem_rdata,
        input  i_stall,
        input  i_flush,
        input  i_redirect,
        input  i_redirect_pc,
        output o_id_valid,
        output o_id_inst,
        output o_id_pc,
        output o_id_pc4
    );

    modport slave (
        input  o_imem_req,
        input  o_imem_addr,
        output i_imem_rdy,
        output i_imem_rvalid,
        output i_imem_rdata,
        output i_stall,
        output i_flush,
        output i_redirect,
        output i_redirect_pc,
        input  o_id_valid,
        input  o_id_inst,
        input  o_id_pc,
        input  o_id_pc4
    );
endinterface

// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//
// Instruction-fetch stage and IF/ID pipeline register of the RV32I core.
// Owns the fetch PC, issues word reads to instruction memory with at most
// one request outstanding, and hands instructions to decode through the
// IF/ID register. A one-entry hold buffer absorbs the single response that
// can land while decode is stalled, so nothing is lost or duplicated.
// Redirects (taken branch/jump) restart fetch at a new PC; a response that
// belongs to a request issued before the redirect is discarded.
//
// Parameters
//   RESET_PC   first fetch address after reset (word aligned)
//   NOP_INST   instruction presented when the IF/ID slot is empty
//
// Ports
//   i_clk      clock, rising edge
//   i_rst_n    asynchronous active-low reset
//   bus        fetch_stage_if.master: imem channel, pipeline control,
//              IF/ID outputs (see fetch_stage_if.sv)
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    fetch_stage_if.master bus
);

    // IDLE : only right after reset, gives one quiet cycle
    // REQ  : request pending on the bus (or blocked by a full hold buffer)
    // WAIT : exactly one request outstanding
    // DROP : outstanding response is stale and must be swallowed
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t      state_reg, state_next;

    logic [31:0] pc_reg, pc_next;            // next address to issue
    logic [31:0] infl_pc_reg, infl_pc_next;  // address of outstanding request

    logic        hold_valid_reg, hold_valid_next;
    logic [31:0] hold_inst_reg, hold_inst_next;
    logic [31:0] hold_pc_reg, hold_pc_next;

    logic        id_valid_reg, id_valid_next;
    logic [31:0] id_inst_reg, id_inst_next;
    logic [31:0] id_pc_reg, id_pc_next;

    logic        kill;          // IF/ID and hold contents die this cycle
    logic        resp_live;     // response belongs to the current fetch stream
    logic        ifid_open;     // IF/ID register loads this cycle
    logic        resp_to_ifid;  // live response goes straight into IF/ID
    logic        imem_req;
    logic        accept;

    // -----------------------------------------------------------------------
    // Shared decode of this cycle's events
    // -----------------------------------------------------------------------
    assign kill      = bus.i_flush | bus.i_redirect;
    // A redirect discards whatever arrives in the same cycle.
    assign resp_live = (state_reg == WAIT) & bus.i_imem_rvalid & ~bus.i_redirect;
    // Flush overrides stall: an emptied slot may take the live response.
    assign ifid_open = kill | ~bus.i_stall | ~id_valid_reg;
    // While hold_valid no request is ever issued, so a live response and a
    // full hold buffer never meet; the response may use the open slot.
    assign resp_to_ifid = resp_live & ifid_open;

    assign accept = imem_req & bus.i_imem_rdy;

    // -----------------------------------------------------------------------
    // FSM: state register
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // -----------------------------------------------------------------------
    // FSM: next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next = state_reg;
        unique case (state_reg)
            IDLE: begin
                state_next = REQ;
            end
            REQ: begin
                if (bus.i_redirect) begin
                    // A request accepted alongside the redirect fetches the
                    // old PC; its response must be thrown away.
                    state_next = accept ? DROP : REQ;
                end else if (accept) begin
                    state_next = WAIT;
                end
            end
            WAIT: begin
                if (bus.i_redirect) begin
                    state_next = bus.i_imem_rvalid ? REQ : DROP;
                end else if (bus.i_imem_rvalid) begin
                    // Back-to-back request keeps one in flight.
                    state_next = accept ? WAIT : REQ;
                end
            end
            DROP: begin
                if (bus.i_imem_rvalid) begin
                    state_next = REQ;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // FSM: outputs
    // -----------------------------------------------------------------------
    always_comb begin
        imem_req = 1'b0;
        unique case (state_reg)
            REQ:     imem_req = ~hold_valid_reg;
            // Issue the next request in the same cycle as the response only
            // when that response does not need the hold buffer.
            WAIT:    imem_req = resp_to_ifid;
            default: imem_req = 1'b0;
        endcase
    end

    assign bus.o_imem_req  = imem_req;
    assign bus.o_imem_addr = pc_reg;

    // -----------------------------------------------------------------------
    // Datapath next-state: PC, hold buffer, IF/ID
    // -----------------------------------------------------------------------
    always_comb begin
        pc_next        = pc_reg;
        infl_pc_next   = infl_pc_reg;
        hold_valid_next = hold_valid_reg;
        hold_inst_next = hold_inst_reg;
        hold_pc_next   = hold_pc_reg;
        id_valid_next  = id_valid_reg;
        id_inst_next   = id_inst_reg;
        id_pc_next     = id_pc_reg;

        // Fetch PC: redirect wins over the post-accept increment.
        if (bus.i_redirect) begin
            pc_next = {bus.i_redirect_pc[31:2], 2'b00};
        end else if (accept) begin
            pc_next = pc_reg + 32'd4;
        end

        if (accept) begin
            infl_pc_next = pc_reg;
        end

        // Hold buffer: emptied by kill or by draining into IF/ID; filled by
        // a live response that finds IF/ID occupied and stalled.
        if (kill) begin
            hold_valid_next = 1'b0;
        end else if (ifid_open && hold_valid_reg) begin
            hold_valid_next = 1'b0;
        end else if (resp_live && !resp_to_ifid) begin
            hold_valid_next = 1'b1;
            hold_inst_next  = bus.i_imem_rdata;
            hold_pc_next    = infl_pc_reg;
        end

        // IF/ID: the hold buffer is older than any live response, so it
        // drains first. Killed hold contents are skipped.
        if (ifid_open) begin
            if (hold_valid_reg && !kill) begin
                id_valid_next = 1'b1;
                id_inst_next  = hold_inst_reg;
                id_pc_next    = hold_pc_reg;
            end else if (resp_live) begin
                id_valid_next = 1'b1;
                id_inst_next  = bus.i_imem_rdata;
                id_pc_next    = infl_pc_reg;
            end else begin
                id_valid_next = 1'b0;
                id_inst_next  = NOP_INST;
            end
        end
    end

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            pc_reg         <= RESET_PC;
            infl_pc_reg    <= RESET_PC;
            hold_valid_reg <= 1'b0;
            hold_inst_reg  <= NOP_INST;
            hold_pc_reg    <= 32'd0;
            id_valid_reg   <= 1'b0;
            id_inst_reg    <= NOP_INST;
            id_pc_reg      <= 32'd0;
        end else begin
            pc_reg         <= pc_next;
            infl_pc_reg    <= infl_pc_next;
            hold_valid_reg <= hold_valid_next;
            hold_inst_reg  <= hold_inst_next;
            hold_pc_reg    <= hold_pc_next;
            id_valid_reg   <= id_valid_next;
            id_inst_reg    <= id_inst_next;
            id_pc_reg      <= id_pc_next;
        end
    end

    assign bus.o_id_valid = id_valid_reg;
    assign bus.o_id_inst  = id_inst_reg;
    assign bus.o_id_pc    = id_pc_reg;
    assign bus.o_id_pc4   = id_pc_reg + 32'd4;   // wraps at 2^32

endmodule

// File: tb/tb_fetch_stage.sv
`timescale 1ns/1ps
module tb_fetch_stage;

    localparam logic [31:0] NOP  = 32'h0000_0013;
    localparam logic [31:0] MASK = 32'hA5A5_0000;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fetch_stage_if bus ();
    fetch_stage_if bus_w ();

    fetch_stage #(.RESET_PC(32'h0000_0000), .NOP_INST(NOP)) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus)
    );

    // Second instance exercising PC wrap-around.
    fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NOP_INST(NOP)) dut_w (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus_w)
    );

    int checks = 0;
    int passed = 0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ MASK;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed=%08h expected=%08h", tag, obs, exp);
    endtask

    // ---------------- memory model (main instance) ----------------
    typedef struct { logic [31:0] addr; int id; int dly; } mem_t;
    mem_t mem_q[$];
    int   lat_lo = 1;
    int   lat_hi = 1;
    int   next_id = 0;

    // ---------------- reference model ----------------
    // Queue of accepted, still-live fetches in program order; 'ret' marks
    // that memory has answered. Decode sees them strictly in order.
    typedef struct { logic [31:0] addr; int id; bit ret; } exp_t;
    exp_t        exp_q[$];
    logic [31:0] exp_fetch;
    bit          m_valid;
    logic [31:0] m_pc;

    bit          obs_req, obs_acc, obs_rv;
    logic [31:0] obs_addr;

    task automatic cycle(input bit stall, input bit flush, input bit redir,
                         input logic [31:0] rpc, input bit rdy);
        bit rv;
        int rv_id;
        bit upd;
        logic [31:0] a_exp;
        bus.i_stall       = stall;
        bus.i_flush       = flush;
        bus.i_redirect    = redir;
        bus.i_redirect_pc = rpc;
        bus.i_imem_rdy    = rdy;
        rv    = (mem_q.size() > 0) && (mem_q[0].dly == 0);
        rv_id = rv ? mem_q[0].id : -1;
        bus.i_imem_rvalid = rv;
        bus.i_imem_rdata  = rv ? mem_word(mem_q[0].addr) : 32'hDEAD_BEEF;
        #1;
        obs_req  = bus.o_imem_req;
        obs_addr = bus.o_imem_addr;
        obs_rv   = rv;
        obs_acc  = bus.o_imem_req && rdy;
        a_exp    = exp_fetch;

        if (obs_req)
            chk("one_outstanding", 32'(mem_q.size() - (rv ? 1 : 0)), 32'd0);
        if (obs_acc) begin
            chk("fetch_addr", obs_addr, a_exp);
            exp_fetch = exp_fetch + 32'd4;
        end
        // Flush kills instructions already returned but not yet in decode.
        if (flush && !redir)
            while (exp_q.size() > 0 && exp_q[0].ret) void'(exp_q.pop_front());
        if (rv)
            foreach (exp_q[k]) if (exp_q[k].id == rv_id) exp_q[k].ret = 1'b1;
        upd = flush || redir || !stall || !m_valid;
        if (redir) begin
            exp_q.delete();
            exp_fetch = {rpc[31:2], 2'b00};
        end
        if (upd) begin
            if (!redir && exp_q.size() > 0 && exp_q[0].ret) begin
                m_valid = 1'b1;
                m_pc    = exp_q[0].addr;
                void'(exp_q.pop_front());
            end else begin
                m_valid = 1'b0;
            end
        end
        if (obs_acc && !redir)
            exp_q.push_back('{a_exp, next_id, 1'b0});

        @(posedge clk);
        if (rv) void'(mem_q.pop_front());
        foreach (mem_q[k]) if (mem_q[k].dly > 0) mem_q[k].dly--;
        if (obs_acc) begin
            mem_q.push_back('{obs_addr, next_id, int'($urandom_range(lat_hi, lat_lo)) - 1});
            next_id++;
        end
        @(negedge clk);

        chk("id_valid", 32'(bus.o_id_valid), 32'(m_valid));
        if (m_valid) begin
            chk("id_pc", bus.o_id_pc, m_pc);
            chk("id_inst", bus.o_id_inst, mem_word(m_pc));
            chk("id_pc4", bus.o_id_pc4, m_pc + 32'd4);
            if (upd) $display("deliver pc=%08h inst=%08h", m_pc, mem_word(m_pc));
        end else begin
            chk("id_inst_nop", bus.o_id_inst, NOP);
        end
    endtask

    // ---------------- wrap instance: zero-wait responder ----------------
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus_w.i_imem_rvalid <= 1'b0;
            bus_w.i_imem_rdata  <= 32'd0;
        end else begin
            bus_w.i_imem_rvalid <= bus_w.o_imem_req && bus_w.i_imem_rdy;
            bus_w.i_imem_rdata  <= mem_word(bus_w.o_imem_addr);
        end
    end

    logic [31:0] w_addr_q[$];
    logic [31:0] w_pc_q[$];
    logic [31:0] w_pc4_q[$];
    logic [31:0] w_inst_q[$];
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus_w.o_imem_req && bus_w.i_imem_rdy && w_addr_q.size() < 4)
                w_addr_q.push_back(bus_w.o_imem_addr);
            if (bus_w.o_id_valid && w_pc_q.size() < 4) begin
                w_pc_q.push_back(bus_w.o_id_pc);
                w_pc4_q.push_back(bus_w.o_id_pc4);
                w_inst_q.push_back(bus_w.o_id_inst);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit          st, fl, rd, ry;
        logic [31:0] tgt;

        bus.i_stall = 1'b0;  bus.i_flush = 1'b0;  bus.i_redirect = 1'b0;
        bus.i_redirect_pc = 32'd0;  bus.i_imem_rdy = 1'b0;
        bus.i_imem_rvalid = 1'b0;   bus.i_imem_rdata = 32'd0;
        bus_w.i_stall = 1'b0; bus_w.i_flush = 1'b0; bus_w.i_redirect = 1'b0;
        bus_w.i_redirect_pc = 32'd0; bus_w.i_imem_rdy = 1'b1;
        exp_fetch = 32'd0;
        m_valid   = 1'b0;
        m_pc      = 32'd0;

        // Reset values
        repeat (2) @(negedge clk);
        chk("rst_req", 32'(bus.o_imem_req), 32'd0);
        chk("rst_valid", 32'(bus.o_id_valid), 32'd0);
        chk("rst_inst", bus.o_id_inst, NOP);
        chk("rst_pc", bus.o_id_pc, 32'd0);
        chk("rst_pc4", bus.o_id_pc4, 32'd4);
        chk("rst_addr", bus.o_imem_addr, 32'd0);
        rst_n = 1'b1;

        // First request appears in the 2nd cycle after release
        cycle(0, 0, 0, 32'd0, 1);
        chk("first_req_c1", 32'(obs_req), 32'd0);
        cycle(0, 0, 0, 32'd0, 1);
        chk("first_req_c2", 32'(obs_req), 32'd1);
        chk("first_addr", obs_addr, 32'd0);

        // Zero-wait streaming
        repeat (8) cycle(0, 0, 0, 32'd0, 1);

        // Stall 3 cycles: hold fills, no requests while it is full
        cycle(1, 0, 0, 32'd0, 1);
        cycle(1, 0, 0, 32'd0, 1);
        chk("stall_noreq1", 32'(obs_req), 32'd0);
        cycle(1, 0, 0, 32'd0, 1);
        chk("stall_noreq2", 32'(obs_req), 32'd0);
        repeat (6) cycle(0, 0, 0, 32'd0, 1);

        // Redirect to 0x100 with a slow request in flight
        lat_lo = 3; lat_hi = 3;
        for (int n = 0; n < 10; n++) begin
            cycle(0, 0, 0, 32'd0, 1);
            if (obs_acc) break;
        end
        chk("slow_req_accepted", 32'(obs_acc), 32'd1);
        cycle(0, 0, 1, 32'h100, 1);
        chk("redir_noreq0", 32'(obs_req), 32'd0);
        cycle(0, 0, 0, 32'd0, 1);
        chk("drop_noreq1", 32'(obs_req), 32'd0);
        cycle(0, 0, 0, 32'd0, 1);
        chk("drop_stale_rv", 32'(obs_rv), 32'd1);
        chk("drop_noreq2", 32'(obs_req), 32'd0);
        cycle(0, 0, 0, 32'd0, 1);
        chk("redir_req", 32'(obs_req), 32'd1);
        chk("redir_addr", obs_addr, 32'h100);
        repeat (6) cycle(0, 0, 0, 32'd0, 1);

        // Misaligned redirect target is forced to a word address
        lat_lo = 1; lat_hi = 1;
        repeat (6) cycle(0, 0, 0, 32'd0, 1);
        cycle(0, 0, 1, 32'h203, 1);
        cycle(0, 0, 0, 32'd0, 1);
        chk("align_req", 32'(obs_req), 32'd1);
        chk("align_addr", obs_addr, 32'h200);
        repeat (4) cycle(0, 0, 0, 32'd0, 1);

        // Flush with stall high and hold full
        repeat (3) cycle(1, 0, 0, 32'd0, 1);
        cycle(1, 1, 0, 32'd0, 1);
        chk("flush_valid", 32'(bus.o_id_valid), 32'd0);
        chk("flush_nop", bus.o_id_inst, NOP);
        cycle(1, 0, 0, 32'd0, 1);
        chk("flush_resume_req", 32'(obs_req), 32'd1);
        repeat (5) cycle(0, 0, 0, 32'd0, 1);

        // Memory not ready for 4 cycles: request and address held
        for (int n = 0; n < 4; n++) begin
            cycle(0, 0, 0, 32'd0, 0);
            chk("rdylow_req", 32'(obs_req), 32'd1);
            chk("rdylow_addr", obs_addr, exp_fetch);
        end
        repeat (5) cycle(0, 0, 0, 32'd0, 1);

        // Randomized traffic against the reference model
        lat_lo = 1; lat_hi = 4;
        for (int n = 0; n < 1500; n++) begin
            st  = ($urandom_range(99) < 30);
            fl  = ($urandom_range(99) < 3);
            rd  = ($urandom_range(99) < 3);
            ry  = ($urandom_range(99) < 70);
            tgt = $urandom;
            cycle(st, fl, rd, tgt, ry);
        end

        // Wrap-around instance
        chk("wrap_nreq", 32'(w_addr_q.size() >= 2), 32'd1);
        if (w_addr_q.size() >= 2) begin
            chk("wrap_addr0", w_addr_q[0], 32'hFFFF_FFFC);
            chk("wrap_addr1", w_addr_q[1], 32'h0000_0000);
        end
        chk("wrap_ndeliv", 32'(w_pc_q.size() >= 2), 32'd1);
        if (w_pc_q.size() >= 2) begin
            chk("wrap_pc0", w_pc_q[0], 32'hFFFF_FFFC);
            chk("wrap_pc4_0", w_pc4_q[0], 32'h0000_0000);
            chk("wrap_inst0", w_inst_q[0], mem_word(32'hFFFF_FFFC));
            chk("wrap_pc1", w_pc_q[1], 32'h0000_0000);
        end

        // Asynchronous reset assertion away from any clock edge
        @(negedge clk);
        bus.i_stall = 1'b0; bus.i_redirect = 1'b0; bus.i_flush = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_req", 32'(bus.o_imem_req), 32'd0);
        chk("arst_valid", 32'(bus.o_id_valid), 32'd0);
        chk("arst_inst", bus.o_id_inst, NOP);
        chk("arst_pc4", bus.o_id_pc4, 32'd4);
        chk("arst_addr", bus.o_imem_addr, 32'd0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage and IF/ID pipeline register of the RV32I core. Owns the PC, issues word requests to instruction memory under a req/rdy handshake with one outstanding request, and absorbs decode stalls in a one-entry hold buffer. Presents a valid instruction, its PC and PC+4 to decode, which drives the immediate generator. Handles branch/jump redirects and discards a stale in-flight response.

## Interface
- RESET_PC, 32'h0000_0000, first fetch address after reset (bits [1:0] must be 0)
- NOP_INST, 32'h0000_0013, value presented on o_id_inst when the slot is invalid
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  asynchronous active-low reset
- o_imem_req  out  1  request valid
- o_imem_addr  out  32  request byte address, word aligned
- i_imem_rdy  in  1  memory accepts request this cycle
- i_imem_rvalid  in  1  read data valid; arrives ≥1 cycle after acceptance
- i_imem_rdata  in  32  instruction word
- i_stall  in  1  decode cannot accept; hold IF/ID
- i_flush  in  1  kill IF/ID and hold buffer contents
- i_redirect  in  1  change fetch PC (taken branch/jump)
- i_redirect_pc  in  32  redirect target; bits [1:0] forced to 0
- o_id_valid  out  1  IF/ID slot holds a live instruction
- o_id_inst  out  32  instruction (NOP_INST when invalid)
- o_id_pc  out  32  PC of o_id_inst
- o_id_pc4  out  32  o_id_pc + 4, mod 2^32

## Operation
- Registers: pc_q (next address to issue), infl_pc (address of outstanding request), state, hold_valid/hold_inst/hold_pc, IF/ID (valid, inst, pc).
- States: IDLE (after reset only), REQ (request pending), WAIT (one request outstanding), DROP (outstanding response must be discarded).
- o_imem_addr = pc_q. o_imem_req = (state==REQ & ~hold_valid) | (state==WAIT & i_imem_rvalid & ~i_redirect & response_taken_by_IFID).
- Accept = o_imem_req & i_imem_rdy: infl_pc <= pc_q, pc_q <= pc_q+4 (wraps at 2^32), state -> WAIT. REQ without accept stays REQ.
- IDLE -> REQ unconditionally.
- WAIT, i_imem_rvalid, no redirect: response routed to IF/ID if IF/ID empty or not stalled, else to hold buffer. Next state WAIT if a back-to-back request was accepted, else REQ.
- IF/ID update when ~i_stall | ~o_id_valid: load hold buffer if hold_valid (hold cleared), else the live response, else valid=0/inst=NOP_INST. Hold and an outstanding response never coexist, since no request issues while hold_valid.
- i_flush: IF/ID valid<=0, inst<=NOP_INST, hold_valid<=0; the current response is still delivered into the empty IF/ID. Flush overrides stall.
- i_redirect: implies flush, and the current-cycle response is discarded. pc_q <= i_redirect_pc (no +4). If a request is outstanding with no rvalid this cycle, or a request is accepted this cycle: -> DROP. Otherwise -> REQ.
- DROP: o_imem_req=0; on i_imem_rvalid discard data and go to REQ. A redirect in DROP only updates pc_q.
- Response in REQ or IDLE (protocol violation): ignored.

## Timing
- Reset (async assert): pc_q=RESET_PC, state=IDLE, o_imem_req=0, o_id_valid=0, o_id_inst=NOP_INST, o_id_pc=0, o_id_pc4=4, hold_valid=0.
- First o_imem_req=1 in the 2nd cycle after reset release.
- Zero-wait memory (rdy=1, rvalid one cycle after accept): one instruction per cycle. o_id_valid rises 1 cycle after rvalid. Fetch-to-decode latency is 2 cycles from accept.
- Redirect in cycle N: with nothing in flight, first request to the target in N+1. With a request in flight, the request follows the stale rvalid by 1 cycle.
- Stall: o_id_* stable while i_stall & o_id_valid. At most one extra instruction is buffered. No instruction is lost or duplicated.

## Test plan
- Reset release, zero-wait memory returning addr as data: requests 0x0,0x4,0x8… on consecutive cycles; o_id_pc 0x0,0x4,… one per cycle; o_id_pc4 = pc+4.
- Stall for 3 cycles while streaming: IF/ID frozen, hold captures next word, no req issued. After release the sequence continues with no gap in PC order and no duplicates.
- Redirect to 0x100 while request 0x8 outstanding (rvalid delayed 3 cycles): 0x8 data discarded, next request 0x100, o_id_valid low until 0x100 arrives.
- Redirect with i_redirect_pc=0x203: fetch address 0x200.
- Flush with stall high and hold full: o_id_valid=0, o_id_inst=0x00000013 next cycle, hold emptied. Fetch resumes from pc_q.
- i_imem_rdy low for 4 cycles: o_imem_req and o_imem_addr held stable, pc_q does not advance. PC wrap: RESET_PC=0xFFFF_FFFC, so the second fetch is 0x0 and o_id_pc4 of the first instruction is 0x0.
